b16_uart_monitor: RTL
=====================

# b16_uart_monitor

Host-side debug initiator for the b16 memory bus. It takes command bytes from the board UART receiver and turns them into word reads and writes on the same address/data bus the CPU drives. Read data and completion codes go back out through the UART transmitter. The block sits in the top level beside the `uart` instance and muxes onto the memory bus while it holds the CPU stopped. This lets the host load boot code into SRAM or bootram and inspect memory without reflashing.

## Interface
Parameters:
- `ACK_CODE`, default 8'h06: byte sent after a completed write or address set.
- `ERR_CODE`, default 8'h3F: byte sent for an unknown opcode.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain). One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  transmit request.
- `tx_ready`  in  1  transmitter accepts `tx_data` on an edge where `tx_valid & tx_ready`.
- `hold`  out  1  when high, the top level stops the CPU and routes this block's bus outputs.
- `bus_addr`  out  16  byte address; bit 0 is always 0.
- `bus_r`  out  1  read request.
- `bus_w`  out  2  byte write enables; this block drives only 2'b11 or 2'b00.
- `bus_dwrite`  out  16  write data.
- `bus_data`  in  16  read data; valid on the edge where `bus_ack` is high.
- `bus_ack`  in  1  access complete.
- `overrun`  out  1  sticky: an `rx_valid` arrived while the FSM was not accepting bytes.

## Operation
Opcodes (first byte of a command):
- 8'h01 SETA, followed by hi and lo bytes: sets `addr = {hi, lo} & 16'hFFFE`, then sends `ACK_CODE`.
- 8'h02 WRITE, followed by hi and lo bytes: writes word `{hi, lo}` to `addr`, `addr += 2`, then sends `ACK_CODE`.
- 8'h03 READ, no arguments: reads `addr`, sends hi byte then lo byte, `addr += 2`.
- 8'h04 HOLD, followed by one byte: `hold <= byte[0]`, then sends `ACK_CODE`.
- Any other opcode: sends `ERR_CODE`. State is otherwise unchanged.

Rules:
- Address arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000.
- WRITE and READ are executed regardless of `hold`. Arbitration is the top level's job.

States:
- `IDLE`: `rx_valid` latches the opcode. Goes to `ARG1` for SETA/WRITE/HOLD, to `BUS` for READ, to `TX1` (ERR) for anything else.
- `ARG1`: `rx_valid` latches the hi byte; HOLD applies its byte here instead. Goes to `ARG2`, or to `TX1` for HOLD.
- `ARG2`: `rx_valid` latches the lo byte. SETA goes to `TX1`; WRITE goes to `BUS`.
- `BUS`: drives the access until `bus_ack`. Then goes to `TX1`.
- `TX1`: sends the ACK/ERR code or the read hi byte. On accept, goes to `IDLE`, or to `TX2` for READ.
- `TX2`: sends the read lo byte. On accept, goes to `IDLE`.

Overrun:
- Bytes are accepted only in `IDLE`, `ARG1` and `ARG2`.
- An `rx_valid` in `BUS`, `TX1` or `TX2` is discarded and sets `overrun`.

## Timing
Reset values (on any edge with `reset` high, including mid-command):
- State `IDLE`, `addr` 0, `hold` 0.
- `bus_r` 0, `bus_w` 0, `bus_dwrite` 0.
- `tx_valid` 0, `tx_data` 0, `overrun` 0.
- Any in-progress bus cycle or transmit is abandoned, with requests dropped the same edge.

All outputs are registered.

Bus cycle:
- `bus_r`/`bus_w` rise on the edge that enters `BUS`.
- `bus_addr` and `bus_dwrite` are stable for the whole access.
- On the first edge with `bus_ack` high:
  - read data is captured;
  - `addr` increments;
  - requests drop to 0 at that same edge, so they are never high in `TX1`.
- `bus_ack` low indefinitely means the block waits forever. There is no timeout.
- Minimum access is one cycle, with `bus_ack` high in the first `BUS` cycle.

Transmit:
- `tx_valid` rises with the edge entering `TX1`/`TX2`.
- `tx_data` is constant while `tx_valid & !tx_ready`.
- `tx_valid` drops, or reloads for `TX2`, on the accepting edge.

Latency:
- READ opcode strobe → `bus_r` high: 1 cycle.
- `bus_ack` → `tx_valid`: 1 cycle.

Simultaneous events:
- `rx_valid` and `reset` on the same edge: reset wins.
- `rx_valid` on the edge that returns to `IDLE` from `TX*` counts as overrun. `IDLE` accepts bytes starting the following cycle.

## Test plan
- Reset mid-WRITE (after hi byte) → next cycle state `IDLE`, all outputs at reset values. A following READ is issued to `bus_addr` 16'h0000.
- Bytes 01 12 35, `tx_ready`=1 → one `tx` of 8'h06, `bus_addr` = 16'h1234 (bit 0 cleared). No bus request is ever asserted.
- Bytes 02 BE EF with `bus_ack` held low 3 cycles → `bus_w`=2'b11 for exactly 4 cycles with `bus_dwrite`=16'hBEEF, then 8'h06 sent, `addr` advances by 2.
- SETA 16'hFFFE then READ with `bus_data`=16'hA55A → tx sequence A5, 5A. Next READ is issued at 16'h0000.
- Opcode 8'h7F → `ERR_CODE` 8'h3F sent, `addr` and `hold` unchanged.
- HOLD 01 then HOLD 00 → `hold` 1 then 0, two ACKs. Extra: an `rx_valid` injected while `tx_ready`=0 in `TX1` → byte dropped, `overrun`=1 until reset.

Source files
------------

// File: rtl/b16_uart_monitor.sv
// UART-driven debug initiator for the b16 memory bus: SETA/WRITE/READ/HOLD commands
// arrive as bytes, bus accesses are issued, and ACK/ERR/read bytes go back to the UART.
module b16_uart_monitor #(
   parameter logic [7:0] ACK_CODE = 8'h06,
   parameter logic [7:0] ERR_CODE = 8'h3F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        hold,
   output logic [15:0] bus_addr,
   output logic        bus_r,
   output logic [1:0]  bus_w,
   output logic [15:0] bus_dwrite,
   input  logic [15:0] bus_data,
   input  logic        bus_ack,
   output logic        overrun
);

   localparam int unsigned BW = 8;
   localparam int unsigned AW = 16;

   localparam logic [BW-1:0] OP_SETA  = 8'h01;
   localparam logic [BW-1:0] OP_WRITE = 8'h02;
   localparam logic [BW-1:0] OP_READ  = 8'h03;
   localparam logic [BW-1:0] OP_HOLD  = 8'h04;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARG1 = 3'd1,
      ARG2 = 3'd2,
      BUS  = 3'd3,
      TX1  = 3'd4,
      TX2  = 3'd5
   } state_t;

   state_t        state, state_d;
   logic [BW-1:0] op, op_d;
   logic [BW-1:0] hi, hi_d;
   logic [BW-1:0] rd_lo, rd_lo_d;
   logic [AW-1:0] addr, addr_d;
   logic          hold_d, bus_r_d, tx_valid_d, overrun_d;
   logic [1:0]    bus_w_d;
   logic [AW-1:0] bus_dwrite_d;
   logic [BW-1:0] tx_data_d;

   assign bus_addr = addr;

   // State and all output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op         <= '0;
         hi         <= '0;
         rd_lo      <= '0;
         addr       <= '0;
         hold       <= 1'b0;
         bus_r      <= 1'b0;
         bus_w      <= 2'b00;
         bus_dwrite <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_d;
         op         <= op_d;
         hi         <= hi_d;
         rd_lo      <= rd_lo_d;
         addr       <= addr_d;
         hold       <= hold_d;
         bus_r      <= bus_r_d;
         bus_w      <= bus_w_d;
         bus_dwrite <= bus_dwrite_d;
         tx_data    <= tx_data_d;
         tx_valid   <= tx_valid_d;
         overrun    <= overrun_d;
      end
   end

   // Command decode, bus sequencing and transmit handshake
   always_comb begin
      state_d      = state;
      op_d         = op;
      hi_d         = hi;
      rd_lo_d      = rd_lo;
      addr_d       = addr;
      hold_d       = hold;
      bus_r_d      = bus_r;
      bus_w_d      = bus_w;
      bus_dwrite_d = bus_dwrite;
      tx_data_d    = tx_data;
      tx_valid_d   = tx_valid;
      overrun_d    = overrun;

      unique case (state)
         IDLE: begin
            if (rx_valid) begin
               op_d = rx_data;
               if (rx_data == OP_SETA || rx_data == OP_WRITE || rx_data == OP_HOLD) begin
                  state_d = ARG1;
               end else if (rx_data == OP_READ) begin
                  state_d = BUS;
                  bus_r_d = 1'b1;
               end else begin
                  state_d    = TX1;
                  tx_valid_d = 1'b1;
                  tx_data_d  = ERR_CODE;
               end
            end
         end
         ARG1: begin
            if (rx_valid) begin
               if (op == OP_HOLD) begin
                  hold_d     = rx_data[0];
                  state_d    = TX1;
                  tx_valid_d = 1'b1;
                  tx_data_d  = ACK_CODE;
               end else begin
                  hi_d    = rx_data;
                  state_d = ARG2;
               end
            end
         end
         ARG2: begin
            if (rx_valid) begin
               if (op == OP_SETA) begin
                  addr_d     = {hi, rx_data} & 16'hFFFE;
                  state_d    = TX1;
                  tx_valid_d = 1'b1;
                  tx_data_d  = ACK_CODE;
               end else begin
                  bus_dwrite_d = {hi, rx_data};
                  bus_w_d      = 2'b11;
                  state_d      = BUS;
               end
            end
         end
         BUS: begin
            if (rx_valid) overrun_d = 1'b1;
            if (bus_ack) begin
               bus_r_d    = 1'b0;
               bus_w_d    = 2'b00;
               addr_d     = addr + AW'(2);
               state_d    = TX1;
               tx_valid_d = 1'b1;
               if (op == OP_READ) begin
                  tx_data_d = bus_data[15:8];
                  rd_lo_d   = bus_data[7:0];
               end else begin
                  tx_data_d = ACK_CODE;
               end
            end
         end
         TX1: begin
            if (rx_valid) overrun_d = 1'b1;
            if (tx_ready) begin
               if (op == OP_READ) begin
                  state_d   = TX2;
                  tx_data_d = rd_lo;
               end else begin
                  state_d    = IDLE;
                  tx_valid_d = 1'b0;
               end
            end
         end
         TX2: begin
            if (rx_valid) overrun_d = 1'b1;
            if (tx_ready) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
